// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
//   Elastic pipeline register placed between two pipeline stages. It carries a
//   control field, which reads as all-zero (a NOP) whenever no entry is held, and
//   a data payload. Transfers use a valid/ready handshake.
//
//   With SKID=1 the stage holds up to two entries: a head register that drives
//   out_* and a skid register for the second entry. in_ready then comes from a
//   flop, so there is no combinational path from out_ready to in_ready. With
//   SKID=0 the stage holds one entry and in_ready depends combinationally on
//   out_ready.
//
//   Two saturating counters report activity:
//     stall_cnt : cycles in which an entry is offered downstream but not taken
//     flush_cnt : flush cycles that threw away at least one held entry
//
// Ports
//   clk        in   1       clock; all state changes on the rising edge
//   rst        in   1       synchronous reset, active low
//   flush      in   1       drop all held entries (takes priority over handshakes)
//   in_valid   in   1       upstream presents an entry
//   in_ready   out  1       stage can accept an entry this cycle
//   in_ctrl    in   CTRL_W  upstream control field
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       head entry valid to downstream
//   out_ready  in   1       downstream takes the head entry (low = stall)
//   out_ctrl   out  CTRL_W  head control field, zero when out_valid=0
//   out_data   out  DATA_W  head payload, stable but meaningless when out_valid=0
//   occupancy  out  2       number of held entries
//   stall_cnt  out  CNT_W   saturating stall cycle count
//   flush_cnt  out  CNT_W   saturating count of flushes that dropped entries
// ----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 12,
    parameter int unsigned DATA_W = 143,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // State encoding equals the number of held entries.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e             r_state;
    state_e             w_state_next;

    logic [CTRL_W-1:0]  r_head_ctrl;
    logic [DATA_W-1:0]  r_head_data;
    logic [CTRL_W-1:0]  r_skid_ctrl;
    logic [DATA_W-1:0]  r_skid_data;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    logic               w_accept;
    logic               w_issue;
    logic               w_out_valid;
    logic               w_load_head_in;
    logic               w_load_head_skid;
    logic               w_load_skid;
    logic               w_clear_head;

    assign w_out_valid = (r_state != StEmpty);
    assign w_accept    = in_valid & in_ready;
    assign w_issue     = w_out_valid & out_ready;

    // ------------------------------------------------------------------------
    // Ready generation
    // ------------------------------------------------------------------------
    if (SKID != 0) begin : g_skid
        logic r_in_ready;

        // Registered copy of "next state is not full", so in_ready never sees
        // out_ready combinationally.
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_in_ready <= 1'b1;
            end else begin
                r_in_ready <= (w_state_next != StFull);
            end
        end

        assign in_ready = r_in_ready;
    end else begin : g_noskid
        assign in_ready = ~w_out_valid | out_ready;
    end

    // ------------------------------------------------------------------------
    // Occupancy FSM: next state and register load strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_clear_head     = 1'b0;

        if (flush) begin
            // Any accept this cycle is dropped along with the held entries.
            w_state_next = StEmpty;
            w_clear_head = 1'b1;
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_accept) begin
                        w_state_next   = StOne;
                        w_load_head_in = 1'b1;
                    end
                end
                StOne: begin
                    if (w_accept && w_issue) begin
                        w_load_head_in = 1'b1;
                    end else if (w_accept) begin
                        // Unreachable with SKID=0: in_ready is low in this case.
                        w_state_next = StFull;
                        w_load_skid  = 1'b1;
                    end else if (w_issue) begin
                        w_state_next = StEmpty;
                        w_clear_head = 1'b1;
                    end
                end
                StFull: begin
                    // in_ready is low here, so only an issue can happen.
                    if (w_issue) begin
                        w_state_next     = StOne;
                        w_load_head_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_next = StEmpty;
                    w_clear_head = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Head and skid registers
    // ------------------------------------------------------------------------
    // Control is zeroed whenever the head empties so out_ctrl is a NOP without
    // any output gating; data is left as-is.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head_ctrl <= '0;
            r_head_data <= '0;
        end else if (w_load_head_in) begin
            r_head_ctrl <= in_ctrl;
            r_head_data <= in_data;
        end else if (w_load_head_skid) begin
            r_head_ctrl <= r_skid_ctrl;
            r_head_data <= r_skid_data;
        end else if (w_clear_head) begin
            r_head_ctrl <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (w_load_skid) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
        end
    end

    // ------------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !out_ready && (r_stall_cnt != CntMax)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_flush_cnt <= '0;
        end else if (flush && w_out_valid && (r_flush_cnt != CntMax)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign out_valid = w_out_valid;
    assign out_ctrl  = r_head_ctrl;
    assign out_data  = r_head_data;
    assign occupancy = r_state;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
